// File: rtl/modmul_interleaved_p.sv
// Radix-2 MSB-first interleaved modular multiplier: result = (a*b) mod n, one multiplier bit per cycle.
// Latency WIDTH+2 cycles from accepted start (2 for rejected operands); start is ignored unless idle.
module modmul_interleaved_p #(
  parameter int WIDTH = 128,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH+1:0] n2_q, n2_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] n_ext;
  logic [WIDTH-1:0] t_n_lo;
  logic [WIDTH-1:0] t_2n_lo;
  logic [WIDTH-1:0] r_new;
  logic             op_bad;

  always_comb begin
    // The multiplier operand is shifted left each step, so its MSB is always the current bit.
    n_ext   = {2'b00, n_q};
    t       = {1'b0, r_q, 1'b0} + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
    // Final remainder is below n, so the low WIDTH bits of each difference are exact.
    t_n_lo  = t[WIDTH-1:0] - n_q;
    t_2n_lo = t[WIDTH-1:0] - n2_q[WIDTH-1:0];
    if (t < n_ext) begin
      r_new = t[WIDTH-1:0];
    end else if (t < n2_q) begin
      r_new = t_n_lo;
    end else begin
      r_new = t_2n_lo;
    end
    op_bad = (n_q < WIDTH'(2)) | (a_q >= n_q) | (b_q >= n_q);

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    n2_d     = n2_q;
    r_d      = r_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          n_d     = n;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (op_bad) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_FIN;
        end else begin
          r_d     = '0;
          idx_d   = CNT_W'(WIDTH - 1);
          n2_d    = {1'b0, n_q, 1'b0};
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        r_d   = r_new;
        a_d   = a_q << 1;
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          result_d = r_new;
          err_d    = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_FIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      n2_q     <= '0;
      r_q      <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      n2_q     <= n2_d;
      r_q      <= r_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule
